// File: rtl/rfi_detect_ctrl.sv
// RFI detector controller: sequences statistics flush and warm-up, then flags
// samples whose squared deviation exceeds thresh * variance. Define RFI_CTRL_COUNT_EN to enable the event counter.
module rfi_detect_ctrl #(
  parameter int DIN_WIDTH    = 25,
  parameter int DIN_POINT    = 24,
  parameter int WINDOW_LEN   = 16,
  parameter int THRESH_WIDTH = 8,
  parameter int THRESH_POINT = 4,
  parameter int HOLD_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [DIN_WIDTH-1:0]   din,
  input  logic signed [DIN_WIDTH-1:0]   moving_avg,
  input  logic signed [2*DIN_WIDTH-1:0] moving_var,
  input  logic                          stats_valid,
  input  logic [THRESH_WIDTH-1:0]       thresh,
  input  logic [HOLD_WIDTH-1:0]         hold_len,
  output logic                          stat_rst,
  output logic                          rfi_flag,
  output logic                          flag_valid,
  output logic [1:0]                    state,
  output logic [31:0]                   rfi_count
);

  // state    | meaning
  // S_IDLE   | stopped, outputs low, waiting for enable
  // S_FLUSH  | stat_rst held high for 4 cycles
  // S_WARMUP | statistics settling, WINDOW_LEN stats_valid pulses
  // S_DETECT | per-sample exceed test and hold extension

  localparam int DEV_W  = DIN_WIDTH + 1;
  localparam int SQ_W   = 2 * DEV_W;
  localparam int VAR_W  = 2 * DIN_WIDTH - 1;
  localparam int CMP_W  = SQ_W + THRESH_POINT + THRESH_WIDTH + 1;
  localparam int WCNT_W = $clog2(WINDOW_LEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_WARMUP = 2'd2,
    S_DETECT = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [1:0]                r_flush_cnt;
  logic [WCNT_W-1:0]         r_warm_cnt;
  logic [THRESH_WIDTH-1:0]   r_thresh;
  logic [HOLD_WIDTH-1:0]     r_hold_len;
  logic [HOLD_WIDTH-1:0]     r_hold;

  logic signed [DEV_W-1:0]   w_dev;
  logic signed [SQ_W-1:0]    w_sq;
  logic [VAR_W-1:0]          w_var_pos;
  logic                      r_v1;
  logic [SQ_W-1:0]           r_sq;
  logic [VAR_W-1:0]          r_var;

  logic [CMP_W-1:0]          w_lhs;
  logic [CMP_W-1:0]          w_rhs;
  logic                      w_exceed;
  logic                      r_flag_valid;
  logic                      r_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_next = S_FLUSH;
        S_FLUSH:  if (r_flush_cnt == 2'd0) w_next = S_WARMUP;
        S_WARMUP: if (stats_valid && r_warm_cnt == '0) w_next = S_DETECT;
        S_DETECT: w_next = S_DETECT;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stat_rst = 1'b0;
    if (r_state == S_FLUSH) stat_rst = 1'b1;
  end

  assign state = r_state;

  // Configuration is captured once per run so mid-run writes cannot glitch detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= 2'd0;
      r_warm_cnt  <= '0;
      r_thresh    <= '0;
      r_hold_len  <= '0;
    end else begin
      if (r_state == S_IDLE && w_next == S_FLUSH) begin
        r_flush_cnt <= 2'd3;
        r_thresh    <= thresh;
        r_hold_len  <= hold_len;
      end else if (r_state == S_FLUSH && r_flush_cnt != 2'd0) begin
        r_flush_cnt <= r_flush_cnt - 2'd1;
      end
      if (r_state == S_FLUSH && w_next == S_WARMUP)
        r_warm_cnt <= WCNT_W'(WINDOW_LEN - 1);
      else if (r_state == S_WARMUP && stats_valid && r_warm_cnt != '0)
        r_warm_cnt <= r_warm_cnt - 1'b1;
    end
  end

  assign w_dev     = {din[DIN_WIDTH-1], din} - {moving_avg[DIN_WIDTH-1], moving_avg};
  assign w_sq      = w_dev * w_dev;
  assign w_var_pos = moving_var[2*DIN_WIDTH-1] ? '0 : moving_var[VAR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_sq  <= '0;
      r_var <= '0;
    end else begin
      r_v1 <= enable && (r_state == S_DETECT) && stats_valid;
      if (stats_valid) begin
        r_sq  <= w_sq;
        r_var <= w_var_pos;
      end
    end
  end

  // Both sides carry 2*DIN_POINT+THRESH_POINT fractional bits, so no rescaling is needed.
  assign w_lhs    = CMP_W'(r_sq) << THRESH_POINT;
  assign w_rhs    = CMP_W'(r_thresh) * CMP_W'(r_var);
  assign w_exceed = w_lhs > w_rhs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_valid <= 1'b0;
      r_flag       <= 1'b0;
      r_hold       <= '0;
    end else if (!enable) begin
      r_flag_valid <= 1'b0;
      r_flag       <= 1'b0;
      r_hold       <= '0;
    end else begin
      r_flag_valid <= r_v1;
      if (r_v1) begin
        if (w_exceed) begin
          r_flag <= 1'b1;
          r_hold <= r_hold_len;
        end else if (r_hold != '0) begin
          r_flag <= 1'b1;
          r_hold <= r_hold - 1'b1;
        end else begin
          r_flag <= 1'b0;
        end
      end else begin
        r_flag <= 1'b0;
      end
    end
  end

  assign flag_valid = r_flag_valid;
  assign rfi_flag   = r_flag;

`ifdef RFI_CTRL_COUNT_EN
  logic [31:0] r_rfi_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rfi_count <= '0;
    else if (r_v1 && enable && w_exceed && r_rfi_count != 32'hFFFF_FFFF)
      r_rfi_count <= r_rfi_count + 32'd1;
  end

  assign rfi_count = r_rfi_count;
`else
  assign rfi_count = 32'd0;
`endif

endmodule

// File: tb/tb_rfi_detect_ctrl.sv
// Directed self-checking bench for rfi_detect_ctrl: sequencing, threshold
// decisions, hold extension, abort, async reset and negative variance.
module tb_rfi_detect_ctrl;

  localparam int DW = 25;

  localparam longint Q_DIN   = -64'sd3355443;    // -0.2
  localparam longint E_DIN   = 64'sd13421773;    //  0.8
  localparam longint AVG_NEG = -64'sd13421773;   // -0.8
  localparam longint VAR_Q   = 64'sd70368744177664; // 0.25 at 48 frac bits

`ifdef RFI_CTRL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enable;
  logic signed [DW-1:0]   din;
  logic signed [DW-1:0]   moving_avg;
  logic signed [2*DW-1:0] moving_var;
  logic                   stats_valid;
  logic [7:0]             thresh;
  logic [7:0]             hold_len;
  logic                   stat_rst;
  logic                   rfi_flag;
  logic                   flag_valid;
  logic [1:0]             state;
  logic [31:0]            rfi_count;

  int n_tests = 0;
  int n_fail  = 0;

  longint v_din [0:15];
  longint v_var [0:15];
  bit     v_sv  [0:15];
  bit     v_fl  [0:15];

  rfi_detect_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .din         (din),
    .moving_avg  (moving_avg),
    .moving_var  (moving_var),
    .stats_valid (stats_valid),
    .thresh      (thresh),
    .hold_len    (hold_len),
    .stat_rst    (stat_rst),
    .rfi_flag    (rfi_flag),
    .flag_valid  (flag_valid),
    .state       (state),
    .rfi_count   (rfi_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input longint d, input longint v, input bit sv, input bit fl);
    v_din[i] = d;
    v_var[i] = v;
    v_sv[i]  = sv;
    v_fl[i]  = fl;
  endtask

  // Restart a run: stop, program, flush (4 cycles) and warm up (16 pulses).
  task automatic start_run(input logic [7:0] t, input logic [7:0] h, input longint avg);
    bit [1:0] exp_st [0:4];
    exp_st = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    enable      = 1'b0;
    stats_valid = 1'b0;
    tick();
    chk("idle_state", state, 0);
    thresh     = t;
    hold_len   = h;
    moving_avg = DW'(avg);
    din        = DW'(avg);
    enable     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("flush_state%0d", k), state, exp_st[k]);
      chk($sformatf("flush_srst%0d", k), stat_rst, (k < 4) ? 1 : 0);
      if (k == 0) begin
        thresh   = 8'h00;
        hold_len = 8'hFF;
      end
    end
    stats_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("warm_state%0d", k), state, (k < 15) ? 2 : 3);
      chk($sformatf("warm_fv%0d", k), flag_valid, 0);
    end
    stats_valid = 1'b0;
  endtask

  // Outputs for input step i appear after the edge of step i+1.
  task automatic run_vec(input int run, input int n);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        din         = DW'(v_din[i]);
        moving_var  = (2*DW)'(v_var[i]);
        stats_valid = v_sv[i];
      end else begin
        stats_valid = 1'b0;
      end
      tick();
      if (i == 0) begin
        chk($sformatf("r%0d_lat", run), flag_valid, 0);
      end else begin
        chk($sformatf("r%0d_fv%0d", run, i - 1), flag_valid, v_sv[i-1]);
        chk($sformatf("r%0d_fl%0d", run, i - 1), rfi_flag, v_sv[i-1] & v_fl[i-1]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    din         = '0;
    moving_avg  = '0;
    moving_var  = '0;
    stats_valid = 1'b0;
    thresh      = '0;
    hold_len    = '0;
    #23;
    chk("rst_state", state, 0);
    chk("rst_srst", stat_rst, 0);
    chk("rst_flag", rfi_flag, 0);
    chk("rst_fv", flag_valid, 0);
    chk("rst_cnt", rfi_count, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", state, 0);

    // thresh 9.0, var 0.25, avg -0.8: dev 0.6 quiet, dev 1.6 exceeds
    start_run(8'h90, 8'd0, AVG_NEG);
    setv(0, Q_DIN, VAR_Q, 1, 0);
    setv(1, E_DIN, VAR_Q, 1, 1);
    setv(2, Q_DIN, VAR_Q, 1, 0);
    setv(3, E_DIN, VAR_Q, 1, 1);
    setv(4, E_DIN, VAR_Q, 0, 0);
    setv(5, E_DIN, VAR_Q, 1, 1);
    run_vec(1, 6);

    // hold_len 3: single exceed flags 4 samples; retrigger reloads
    start_run(8'h90, 8'd3, AVG_NEG);
    setv(0,  E_DIN, VAR_Q, 1, 1);
    setv(1,  Q_DIN, VAR_Q, 1, 1);
    setv(2,  Q_DIN, VAR_Q, 1, 1);
    setv(3,  Q_DIN, VAR_Q, 1, 1);
    setv(4,  Q_DIN, VAR_Q, 1, 0);
    setv(5,  Q_DIN, VAR_Q, 1, 0);
    setv(6,  E_DIN, VAR_Q, 1, 1);
    setv(7,  Q_DIN, VAR_Q, 1, 1);
    setv(8,  E_DIN, VAR_Q, 1, 1);
    setv(9,  Q_DIN, VAR_Q, 1, 1);
    setv(10, Q_DIN, VAR_Q, 1, 1);
    setv(11, Q_DIN, VAR_Q, 1, 1);
    setv(12, Q_DIN, VAR_Q, 1, 0);
    run_vec(2, 13);
    chk("cnt_after_hold", rfi_count, CNT_EN ? 64'd6 : 64'd0);

    // abort with an exceeding sample in flight
    start_run(8'h90, 8'd0, AVG_NEG);
    din         = DW'(E_DIN);
    moving_var  = (2*DW)'(VAR_Q);
    stats_valid = 1'b1;
    tick();
    stats_valid = 1'b0;
    enable      = 1'b0;
    tick();
    chk("abort_state", state, 0);
    chk("abort_fv", flag_valid, 0);
    chk("abort_flag", rfi_flag, 0);
    tick();
    chk("abort_fv2", flag_valid, 0);
    chk("abort_cnt", rfi_count, CNT_EN ? 64'd6 : 64'd0);

    // async reset while a hold is running
    start_run(8'h90, 8'd3, AVG_NEG);
    din         = DW'(E_DIN);
    moving_var  = (2*DW)'(VAR_Q);
    stats_valid = 1'b1;
    tick();
    din = DW'(Q_DIN);
    tick();
    stats_valid = 1'b0;
    tick();
    chk("hold_flag_pre", rfi_flag, 1);
    chk("hold_cnt_pre", rfi_count, CNT_EN ? 64'd7 : 64'd0);
    #2;
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_flag", rfi_flag, 0);
    chk("arst_fv", flag_valid, 0);
    chk("arst_srst", stat_rst, 0);
    chk("arst_cnt", rfi_count, 0);
    #3;
    rst = 1'b0;
    tick();
    tick();
    chk("arst_stay_idle", state, 0);

    // thresh 1/16, avg 0: negative variance and the equality boundary
    start_run(8'h01, 8'd0, 64'sd0);
    setv(0, 64'sd1,        -64'sd1,             1, 1);
    setv(1, 64'sd0,        -64'sd1,             1, 0);
    setv(2, 64'sd2097152,  VAR_Q,               1, 0);
    setv(3, 64'sd2097153,  VAR_Q,               1, 1);
    setv(4, -64'sd2097153, VAR_Q,               1, 1);
    run_vec(4, 5);
    chk("cnt_final", rfi_count, CNT_EN ? 64'd3 : 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
